// File: rtl/gpio_wb_rr_arbiter_if.sv
// Wishbone bus bundle for gpio_wb_rr_arbiter.
// The master modport faces the NM bus masters and the slave modport faces the shared GPIO slave.
interface gpio_wb_rr_arbiter_if #(
  parameter int NM = 2,
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;

  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [3:0]       s_sel_o;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o
  );

  modport slave (
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/gpio_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one GPIO slave among NM masters.
// Define GPIO_ARB_WATCHDOG_EN to add a watchdog that errors out transfers stalled for TIMEOUT cycles.
module gpio_wb_rr_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  gpio_wb_rr_arbiter_if.master m_if,
  gpio_wb_rr_arbiter_if.slave  s_if
);
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  if (NM < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("gpio_wb_rr_arbiter: NM and TIMEOUT must both be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] rr_pick;
  int            rr_best;
  logic          busy;
  logic          wdog_err;

  logic          g_cyc, g_stb, g_we;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;
  logic [3:0]    g_sel;

  assign busy = (state_q == BUSY);

  always_comb begin
    g_cyc = m_if.m_cyc_i[grant_q];
    g_stb = m_if.m_stb_i[grant_q];
    g_we  = m_if.m_we_i[grant_q];
    g_adr = m_if.m_adr_i[grant_q*AW +: AW];
    g_dat = m_if.m_dat_i[grant_q*DW +: DW];
    g_sel = m_if.m_sel_i[grant_q*4 +: 4];
  end

  // Requester nearest after last in circular order wins: distance 0 is last+1.
  always_comb begin
    rr_pick = last_q;
    rr_best = NM;
    for (int i = 0; i < NM; i++) begin
      if (m_if.m_cyc_i[i] && (((i + NM - 1 - int'(last_q)) % NM) < rr_best)) begin
        rr_best = (i + NM - 1 - int'(last_q)) % NM;
        rr_pick = GW'(i);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_if.m_cyc_i) begin
          grant_d = rr_pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe is gated by cyc so a stray stb from the granted master never reaches the slave.
  always_comb begin
    s_if.s_cyc_o = 1'b0;
    s_if.s_stb_o = 1'b0;
    s_if.s_we_o  = 1'b0;
    s_if.s_adr_o = '0;
    s_if.s_dat_o = '0;
    s_if.s_sel_o = '0;
    m_if.m_ack_o = '0;
    m_if.m_err_o = '0;
    m_if.m_dat_o = s_if.s_dat_i;
    if (busy) begin
      s_if.s_cyc_o          = g_cyc;
      s_if.s_stb_o          = g_cyc & g_stb;
      s_if.s_we_o           = g_we;
      s_if.s_adr_o          = g_adr;
      s_if.s_dat_o          = g_dat;
      s_if.s_sel_o          = g_sel;
      m_if.m_ack_o[grant_q] = s_if.s_ack_i;
      m_if.m_err_o[grant_q] = s_if.s_err_i | wdog_err;
    end
  end

`ifdef GPIO_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          stalled;

  assign stalled = busy & g_cyc & g_stb & ~s_if.s_ack_i & ~s_if.s_err_i;

  // Counter clears itself on the error cycle, so it never reaches TIMEOUT and never wraps.
  always_comb begin
    wdog_d   = '0;
    wdog_err = 1'b0;
    if (stalled) begin
      if (wdog_q == WW'(TIMEOUT - 1)) begin
        wdog_err = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_wb_rr_arbiter.sv
// Self-checking bench for gpio_wb_rr_arbiter (NM=3, TIMEOUT=8).
// Directed scenarios plus randomized traffic checked against an owner/last-index reference model.
module tb_gpio_wb_rr_arbiter;
  localparam int NM      = 3;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
`ifdef GPIO_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpio_wb_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  gpio_wb_rr_arbiter #(
    .NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .m_if     (bus),
    .s_if     (bus)
  );

  // Reference model: owner is the master holding the bus (-1 when nobody does),
  // last is the most recent master to give it up, stall counts unanswered strobes.
  int mdl_owner = -1;
  int mdl_last  = NM - 1;
  int mdl_stall = 0;

  function automatic int rr_next(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++) begin
      if (req[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_owner <= -1;
      mdl_last  <= NM - 1;
      mdl_stall <= 0;
    end else if (mdl_owner < 0) begin
      mdl_owner <= rr_next(bus.m_cyc_i, mdl_last);
      mdl_stall <= 0;
    end else if (!bus.m_cyc_i[mdl_owner]) begin
      mdl_last  <= mdl_owner;
      mdl_owner <= -1;
      mdl_stall <= 0;
    end else if (bus.m_stb_i[mdl_owner] && !bus.s_ack_i && !bus.s_err_i) begin
      mdl_stall <= (mdl_stall + 1 == TIMEOUT) ? 0 : mdl_stall + 1;
    end else begin
      mdl_stall <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.m_cyc_i = '1;
    bus.m_stb_i = '1;
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h1234_5678;
    tick();
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_cyc: got %b expected 0", bus.s_cyc_o); end
    checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_stb: got %b expected 0", bus.s_stb_o); end
    checks++; if (bus.m_ack_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_m_ack: got %b expected 000", bus.m_ack_o); end
    checks++; if (bus.m_err_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_m_err: got %b expected 000", bus.m_err_o); end
    checks++; if (bus.s_adr_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_s_adr: got %h expected 00", bus.s_adr_o); end
    checks++; if (bus.m_dat_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL reset_m_dat: got %h expected 12345678", bus.m_dat_o); end
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    reset_dut();
    bus.m_cyc_i = 3'b001;
    bus.m_stb_i = 3'b001;
    bus.m_we_i  = 3'b001;
    bus.m_adr_i = {8'h00, 8'h00, 8'h04};
    bus.m_dat_i = {32'h0, 32'h0, 32'h0000_00A5};
    bus.m_sel_i = {4'h0, 4'h0, 4'hF};
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_latency_s_cyc: got %b expected 0", bus.s_cyc_o); end
    tick();
    bus.s_ack_i = 1'b1;
    sample();
    checks++; if (bus.s_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_s_cyc: got %b expected 1", bus.s_cyc_o); end
    checks++; if (bus.s_stb_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_s_stb: got %b expected 1", bus.s_stb_o); end
    checks++; if (bus.s_we_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_s_we: got %b expected 1", bus.s_we_o); end
    checks++; if (bus.s_adr_o !== 8'h04) begin errors++; $display("[TB] FAIL wr_s_adr: got %h expected 04", bus.s_adr_o); end
    checks++; if (bus.s_dat_o !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL wr_s_dat: got %h expected 000000a5", bus.s_dat_o); end
    checks++; if (bus.s_sel_o !== 4'hF) begin errors++; $display("[TB] FAIL wr_s_sel: got %h expected f", bus.s_sel_o); end
    checks++; if (bus.m_ack_o !== 3'b001) begin errors++; $display("[TB] FAIL wr_m_ack: got %b expected 001", bus.m_ack_o); end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_rr_order();
    int             got[$];
    int             exp_order[5] = '{0, 1, 2, 0, 1};
    logic [NM-1:0]  acked;
    int             budget;
    reset_dut();
    bus.m_cyc_i = '1;
    bus.m_stb_i = '1;
    bus.m_adr_i = {8'h22, 8'h11, 8'h00};
    bus.s_ack_i = 1'b1;
    budget = 0;
    while (got.size() < 5 && budget < 40) begin
      sample();
      acked = bus.m_ack_o & bus.m_cyc_i;
      for (int i = 0; i < NM; i++) begin
        if (acked[i]) got.push_back(i);
      end
      tick();
      budget++;
      bus.m_cyc_i = ~acked;
      bus.m_stb_i = ~acked;
    end
    checks++; if (got.size() != 5) begin errors++; $display("[TB] FAIL rr_grant_count: got %0d expected 5", got.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < got.size()) begin
        checks++; if (got[k] != exp_order[k]) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", k, got[k], exp_order[k]); end
      end
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ea;
    reset_dut();
    bus.s_ack_i = 1'b1;
    bus.m_cyc_i = 3'b010;
    bus.m_stb_i = 3'b010;
    bus.m_adr_i = {8'h20, 8'h10, 8'h00};
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_s_cyc: got %b expected 0", bus.s_cyc_o); end
    tick();
    bus.m_cyc_i = 3'b110;
    bus.m_stb_i = 3'b110;
    for (int t = 0; t < 3; t++) begin
      ea = 8'h10 + 8'(4 * t);
      bus.m_adr_i[AW +: AW] = ea;
      sample();
      checks++; if (bus.s_adr_o !== ea) begin errors++; $display("[TB] FAIL b2b_s_adr[%0d]: got %h expected %h", t, bus.s_adr_o, ea); end
      checks++; if (bus.m_ack_o !== 3'b010) begin errors++; $display("[TB] FAIL b2b_m_ack[%0d]: got %b expected 010", t, bus.m_ack_o); end
      checks++; if (bus.s_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_s_cyc[%0d]: got %b expected 1", t, bus.s_cyc_o); end
      tick();
    end
    bus.m_cyc_i = 3'b100;
    bus.m_stb_i = 3'b100;
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_release_s_cyc: got %b expected 0", bus.s_cyc_o); end
    tick();
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_dead_s_cyc: got %b expected 0", bus.s_cyc_o); end
    tick();
    sample();
    checks++; if (bus.s_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_m2_s_cyc: got %b expected 1", bus.s_cyc_o); end
    checks++; if (bus.s_adr_o !== 8'h20) begin errors++; $display("[TB] FAIL b2b_m2_s_adr: got %h expected 20", bus.s_adr_o); end
    checks++; if (bus.m_ack_o !== 3'b100) begin errors++; $display("[TB] FAIL b2b_m2_ack: got %b expected 100", bus.m_ack_o); end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_read();
    reset_dut();
    bus.m_cyc_i = 3'b100;
    bus.m_stb_i = 3'b100;
    bus.m_we_i  = 3'b000;
    bus.m_adr_i = {8'h08, 8'h00, 8'h00};
    sample();
    tick();
    bus.s_dat_i = 32'hDEAD_BEEF;
    bus.s_ack_i = 1'b1;
    sample();
    checks++; if (bus.m_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_m_dat: got %h expected deadbeef", bus.m_dat_o); end
    checks++; if (bus.m_ack_o !== 3'b100) begin errors++; $display("[TB] FAIL rd_m_ack: got %b expected 100", bus.m_ack_o); end
    checks++; if (bus.s_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_s_we: got %b expected 0", bus.s_we_o); end
    checks++; if (bus.s_adr_o !== 8'h08) begin errors++; $display("[TB] FAIL rd_s_adr: got %h expected 08", bus.s_adr_o); end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    logic [NM-1:0] e_err;
    reset_dut();
    bus.m_cyc_i = 3'b001;
    bus.m_stb_i = 3'b001;
    sample();
    for (int n = 1; n <= 12; n++) begin
      tick();
      sample();
      e_err = (WD_EN && n == TIMEOUT) ? 3'b001 : 3'b000;
      checks++; if (bus.m_err_o !== e_err) begin errors++; $display("[TB] FAIL wdog_m_err[cycle %0d]: got %b expected %b", n, bus.m_err_o, e_err); end
      if (n == TIMEOUT) begin
        checks++; if (bus.s_stb_o !== 1'b1) begin errors++; $display("[TB] FAIL wdog_s_stb: got %b expected 1", bus.s_stb_o); end
      end
    end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    reset_dut();
    bus.s_ack_i = 1'b1;
    bus.m_adr_i = {8'h2C, 8'h1C, 8'h0C};
    bus.m_cyc_i = 3'b001;
    bus.m_stb_i = 3'b001;
    tick();
    bus.m_cyc_i = 3'b010;
    bus.m_stb_i = 3'b010;
    tick();
    tick();
    sample();
    checks++; if (bus.s_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_s_cyc: got %b expected 1", bus.s_cyc_o); end
    checks++; if (bus.s_adr_o !== 8'h1C) begin errors++; $display("[TB] FAIL arst_pre_s_adr: got %h expected 1c", bus.s_adr_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_s_cyc: got %b expected 0", bus.s_cyc_o); end
    checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_s_stb: got %b expected 0", bus.s_stb_o); end
    bus.m_cyc_i = 3'b111;
    bus.m_stb_i = 3'b111;
    tick();
    rst_n = 1'b1;
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_idle_s_cyc: got %b expected 0", bus.s_cyc_o); end
    tick();
    sample();
    checks++; if (bus.s_adr_o !== 8'h0C) begin errors++; $display("[TB] FAIL arst_first_s_adr: got %h expected 0c", bus.s_adr_o); end
    checks++; if (bus.m_ack_o !== 3'b001) begin errors++; $display("[TB] FAIL arst_first_ack: got %b expected 001", bus.m_ack_o); end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [NM-1:0] cyc_now;
    logic          slow;
    int            o;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [3:0]    e_sel;
    logic [NM-1:0] e_ack, e_err;
    reset_dut();
    cyc_now = '0;
    for (int n = 0; n < 400; n++) begin
      slow = (n >= 200);
      for (int i = 0; i < NM; i++) begin
        if (cyc_now[i]) begin
          if ($urandom_range(0, slow ? 19 : 5) == 0) cyc_now[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          cyc_now[i] = 1'b1;
        end
        bus.m_adr_i[i*AW +: AW] = AW'($urandom);
        bus.m_dat_i[i*DW +: DW] = $urandom;
        bus.m_sel_i[i*4 +: 4]   = 4'($urandom);
      end
      bus.m_cyc_i = cyc_now;
      bus.m_stb_i = slow ? cyc_now : NM'($urandom);
      bus.m_we_i  = NM'($urandom);
      bus.s_ack_i = ($urandom_range(0, slow ? 19 : 1) == 0);
      bus.s_err_i = ($urandom_range(0, 15) == 0);
      bus.s_dat_i = $urandom;
      sample();
      o = mdl_owner;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_adr = '0; e_dat = '0; e_sel = '0;
      e_ack = '0; e_err = '0;
      if (o >= 0) begin
        e_cyc    = bus.m_cyc_i[o];
        e_stb    = bus.m_cyc_i[o] & bus.m_stb_i[o];
        e_we     = bus.m_we_i[o];
        e_adr    = bus.m_adr_i[o*AW +: AW];
        e_dat    = bus.m_dat_i[o*DW +: DW];
        e_sel    = bus.m_sel_i[o*4 +: 4];
        e_ack[o] = bus.s_ack_i;
        e_err[o] = bus.s_err_i |
                   (WD_EN && e_stb && !bus.s_ack_i && !bus.s_err_i && mdl_stall == TIMEOUT - 1);
      end
      checks++; if (bus.s_cyc_o !== e_cyc) begin errors++; $display("[TB] FAIL rnd_s_cyc[%0d]: got %b expected %b", n, bus.s_cyc_o, e_cyc); end
      checks++; if (bus.s_stb_o !== e_stb) begin errors++; $display("[TB] FAIL rnd_s_stb[%0d]: got %b expected %b", n, bus.s_stb_o, e_stb); end
      checks++; if (bus.s_we_o !== e_we) begin errors++; $display("[TB] FAIL rnd_s_we[%0d]: got %b expected %b", n, bus.s_we_o, e_we); end
      checks++; if (bus.s_adr_o !== e_adr) begin errors++; $display("[TB] FAIL rnd_s_adr[%0d]: got %h expected %h", n, bus.s_adr_o, e_adr); end
      checks++; if (bus.s_dat_o !== e_dat) begin errors++; $display("[TB] FAIL rnd_s_dat[%0d]: got %h expected %h", n, bus.s_dat_o, e_dat); end
      checks++; if (bus.s_sel_o !== e_sel) begin errors++; $display("[TB] FAIL rnd_s_sel[%0d]: got %h expected %h", n, bus.s_sel_o, e_sel); end
      checks++; if (bus.m_ack_o !== e_ack) begin errors++; $display("[TB] FAIL rnd_m_ack[%0d]: got %b expected %b", n, bus.m_ack_o, e_ack); end
      checks++; if (bus.m_err_o !== e_err) begin errors++; $display("[TB] FAIL rnd_m_err[%0d]: got %b expected %b", n, bus.m_err_o, e_err); end
      checks++; if (bus.m_dat_o !== bus.s_dat_i) begin errors++; $display("[TB] FAIL rnd_m_dat[%0d]: got %h expected %h", n, bus.m_dat_o, bus.s_dat_i); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_rr_order();
    test_back_to_back();
    test_read();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete within 200000 time units");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
